// File: rtl/video_pattern_source.sv
// video_pattern_source: raster timing generator with a known pixel pattern.
// Drives vsync/hsync/de/field and a {line, column} style word for tap chains.
module video_pattern_source #(
  parameter int DSIZE    = 16,
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1125,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36
) (
  input  logic             clock,
  input  logic             rst_x,
  input  logic             enable,
  input  logic             pause,
  input  logic [1:0]       pattern_sel,
  input  logic [DSIZE-1:0] const_pix,
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic             field,
  output logic [DSIZE-1:0] data,
  output logic [7:0]       frame_cnt,
  output logic             busy
);

  localparam int HALF = DSIZE / 2;
  // One extra bit so the active-window end position always fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYN_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYN_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_step;

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_hwrap;
  logic          w_frame_end;
  logic          w_frame_start;

  logic             w_hs;
  logic             w_vs;
  logic             w_de;
  logic [HALF-1:0]  w_col;
  logic [HALF-1:0]  w_line;
  logic [DSIZE-1:0] w_pix;

  logic             r_vsync;
  logic             r_hsync;
  logic             r_de;
  logic [DSIZE-1:0] r_data;
  logic             r_busy;
  logic             r_field;
  logic [7:0]       r_frame_cnt;
  logic             r_first;

  assign w_hwrap       = (r_hcnt == H_LAST);
  assign w_frame_end   = w_hwrap && (r_vcnt == V_LAST);
  assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (rst_x) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; RUN only leaves at a frame boundary, never mid-frame.
  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!pause) begin
          w_step = 1'b1;
          if (w_frame_end && !enable) begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Raster counters; held at zero while idle, frozen while paused.
  always_ff @(posedge clock) begin
    if (rst_x || r_state == S_IDLE) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_step) begin
      if (w_hwrap) begin
        r_hcnt <= '0;
        if (r_vcnt == V_LAST) begin
          r_vcnt <= '0;
        end else begin
          r_vcnt <= r_vcnt + VW'(1);
        end
      end else begin
        r_hcnt <= r_hcnt + HW'(1);
      end
    end
  end

  assign w_hs = (r_hcnt < H_SYN_END);
  assign w_vs = (r_vcnt < V_SYN_END);
  assign w_de = (r_hcnt >= H_ACT_BEG) && (r_hcnt < H_ACT_END)
             && (r_vcnt >= V_ACT_BEG) && (r_vcnt < V_ACT_END);

  // Fields wrap modulo 2^HALF; only meaningful inside the active window.
  assign w_col  = HALF'(r_hcnt - H_ACT_BEG);
  assign w_line = HALF'(r_vcnt - V_ACT_BEG);

  // Pixel pattern mux; blanking always carries zero.
  always_comb begin
    w_pix = '0;
    if (w_de) begin
      case (pattern_sel)
        2'd0:    w_pix = {w_line, w_col};
        2'd1:    w_pix = const_pix;
        2'd2:    w_pix = {HALF'(r_frame_cnt), w_col};
        default: w_pix = '0;
      endcase
    end
  end

  // Registered timing and pixel outputs, one clock behind the counters.
  always_ff @(posedge clock) begin
    if (rst_x || r_state == S_IDLE) begin
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_de    <= 1'b0;
      r_data  <= '0;
    end else if (!pause) begin
      r_vsync <= w_vs;
      r_hsync <= w_hs;
      r_de    <= w_de;
      r_data  <= w_pix;
    end
  end

  // busy tracks the FSM so it drops on the edge that enters IDLE.
  always_ff @(posedge clock) begin
    if (rst_x) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
    end
  end

  // Frame counter and field; the first frame after IDLE does not count.
  always_ff @(posedge clock) begin
    if (rst_x || r_state == S_IDLE) begin
      r_frame_cnt <= '0;
      r_field     <= 1'b0;
      r_first     <= 1'b1;
    end else if (w_step && w_frame_start) begin
      if (r_first) begin
        r_first <= 1'b0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_field     <= ~r_field;
      end
    end
  end

  assign vsync     = r_vsync;
  assign hsync     = r_hsync;
  assign de        = r_de;
  assign data      = r_data;
  assign busy      = r_busy;
  assign field     = r_field;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: scoreboard bench for the raster pattern source.
// Two instances: a small raster and a wide-line raster for column wrap.
module tb_video_pattern_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_en = 1'b0, a_pause = 1'b0;
  logic [1:0]  a_sel = 2'd0;
  logic [15:0] a_const = 16'h0000;
  logic        a_vs, a_hs, a_de, a_fld, a_busy;
  logic [15:0] a_data;
  logic [7:0]  a_fc;

  logic        b_rst = 1'b1, b_en = 1'b0, b_pause = 1'b0;
  logic [1:0]  b_sel = 2'd0;
  logic [15:0] b_const = 16'h0000;
  logic        b_vs, b_hs, b_de, b_fld, b_busy;
  logic [15:0] b_data;
  logic [7:0]  b_fc;

  video_pattern_source #(
    .DSIZE(16), .H_ACTIVE(8), .H_TOTAL(12), .H_SYNC(1), .H_BACK(2),
    .V_ACTIVE(4), .V_TOTAL(7), .V_SYNC(1), .V_BACK(1)
  ) u_a (
    .clock(clk), .rst_x(a_rst), .enable(a_en), .pause(a_pause),
    .pattern_sel(a_sel), .const_pix(a_const),
    .vsync(a_vs), .hsync(a_hs), .de(a_de), .field(a_fld),
    .data(a_data), .frame_cnt(a_fc), .busy(a_busy)
  );

  video_pattern_source #(
    .DSIZE(16), .H_ACTIVE(300), .H_TOTAL(320), .H_SYNC(1), .H_BACK(2),
    .V_ACTIVE(4), .V_TOTAL(7), .V_SYNC(1), .V_BACK(1)
  ) u_b (
    .clock(clk), .rst_x(b_rst), .enable(b_en), .pause(b_pause),
    .pattern_sel(b_sel), .const_pix(b_const),
    .vsync(b_vs), .hsync(b_hs), .de(b_de), .field(b_fld),
    .data(b_data), .frame_cnt(b_fc), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_on = 1'b0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame_a(int f, int mode);
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 8; c++)
        qa.push_back(mode == 2 ? {8'(f), 8'(c)} : {8'(l), 8'(c)});
  endtask

  // Scoreboard monitors: pop one expected word per displayed pixel.
  always @(negedge clk) begin
    if (mon_on) begin
      if (a_de === 1'b1) begin
        if (qa.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_extra_pixel: got 0x%0h, expected no pixel", a_data);
        end else begin
          chk("a_pixel", a_data, qa.pop_front());
        end
      end else if (a_data !== 16'h0) begin
        chk("a_blank_data", a_data, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (b_de === 1'b1) begin
        if (qb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_extra_pixel: got 0x%0h, expected no pixel", b_data);
        end else begin
          chk("b_pixel", b_data, qb.pop_front());
        end
      end else if (b_data !== 16'h0) begin
        chk("b_blank_data", b_data, 0);
      end
    end
  end

  initial begin
    int first, vs, des;

    // Reset state
    tick();
    chk("rst_outputs_a", {a_vs, a_hs, a_de, a_fld, a_busy, a_data, a_fc}, 0);
    chk("rst_outputs_b", {b_vs, b_hs, b_de, b_fld, b_busy, b_data, b_fc}, 0);
    mon_on = 1'b1;

    // Basic frame
    push_frame_a(0, 0);
    a_rst = 1'b0;
    a_en  = 1'b1;
    tick();
    first = 0; vs = 0; des = 0;
    for (int m = 1; m <= 84; m++) begin
      tick();
      if (a_de && first == 0) first = m;
      vs  += int'(a_vs);
      des += int'(a_de);
      if (m == 1) chk("start_sync", {a_vs, a_hs, a_busy}, 3'b111);
    end
    chk("first_de_latency", first, 28);
    chk("vsync_clocks", vs, 12);
    chk("de_per_frame", des, 32);
    chk("basic_queue_drained", qa.size(), 0);
    a_rst = 1'b1;
    tick();

    // Frame count and field
    a_rst = 1'b0;
    a_sel = 2'd2;
    for (int f = 0; f < 3; f++) push_frame_a(f, 2);
    tick();
    for (int m = 1; m <= 252; m++) begin
      tick();
      if ((m - 1) % 84 == 0) begin
        chk("frame_cnt", a_fc, (m - 1) / 84);
        chk("field", a_fld, ((m - 1) / 84) % 2);
        chk("frame_vsync", a_vs, 1);
      end
    end
    chk("fc_queue_drained", qa.size(), 0);
    a_rst = 1'b1;
    tick();

    // Mid-frame disable
    a_rst = 1'b0;
    a_sel = 2'd0;
    push_frame_a(0, 0);
    tick();
    des = 0;
    for (int m = 1; m <= 84; m++) begin
      tick();
      des += int'(a_de);
      if (m == 41) a_en = 1'b0;
      if (m == 83) chk("busy_before_boundary", a_busy, 1);
      if (m == 84) chk("busy_at_boundary", a_busy, 0);
    end
    chk("disable_full_frame", des, 32);
    for (int m = 0; m < 12; m++) begin
      tick();
      chk("idle_outputs", {a_vs, a_hs, a_de, a_fld, a_busy, a_data, a_fc}, 0);
    end
    chk("disable_queue_drained", qa.size(), 0);

    // Pause
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_en  = 1'b1;
    for (int c = 0; c < 8; c++) qa.push_back({8'h00, 8'(c)});
    qa.push_back(16'h0100);
    qa.push_back(16'h0101);
    for (int i = 0; i < 11; i++) qa.push_back(16'h0102);
    for (int c = 3; c < 8; c++) qa.push_back({8'h01, 8'(c)});
    for (int l = 2; l < 4; l++)
      for (int c = 0; c < 8; c++) qa.push_back({8'(l), 8'(c)});
    tick();
    des = 0;
    for (int m = 1; m <= 94; m++) begin
      tick();
      des += int'(a_de);
      if (m == 42) begin
        chk("pause_entry_data", a_data, 16'h0102);
        a_pause = 1'b1;
      end
      if (m == 47) chk("pause_busy", {a_busy, a_de}, 2'b11);
      if (m == 52) a_pause = 1'b0;
    end
    chk("pause_de_count", des, 42);
    chk("pause_queue_drained", qa.size(), 0);
    a_rst = 1'b1;
    tick();

    // Reset mid-line
    a_rst = 1'b0;
    for (int c = 0; c < 3; c++) qa.push_back({8'h02, 8'(c)} & 16'h00FF);
    tick();
    for (int m = 1; m <= 30; m++) tick();
    chk("de_before_reset", a_de, 1);
    a_rst = 1'b1;
    tick();
    chk("reset_midline", {a_vs, a_hs, a_de, a_busy, a_data, a_fc}, 0);
    chk("reset_queue_drained", qa.size(), 0);
    a_rst = 1'b0;
    push_frame_a(0, 0);
    tick();
    first = 0; des = 0;
    for (int m = 1; m <= 84; m++) begin
      tick();
      if (a_de && first == 0) first = m;
      des += int'(a_de);
    end
    chk("restart_first_de", first, 28);
    chk("restart_de_count", des, 32);
    chk("restart_queue_drained", qa.size(), 0);
    a_rst = 1'b1;
    a_en  = 1'b0;
    tick();

    // Column wrap and constant / zero patterns on the wide raster
    b_rst   = 1'b0;
    b_en    = 1'b1;
    b_sel   = 2'd0;
    b_const = 16'hA5A5;
    for (int c = 0; c < 300; c++)
      qb.push_back(c <= 280 ? {8'h00, 8'(c)} : 16'hA5A5);
    for (int c = 0; c < 300; c++) qb.push_back(16'hA5A5);
    for (int c = 0; c < 600; c++) qb.push_back(16'h0000);
    tick();
    b_en = 1'b0;
    for (int m = 1; m <= 2244; m++) begin
      tick();
      if (m == 644) chk("b_first_de", {b_de, b_data}, 17'h10000);
      if (m == 644 + 255) chk("b_col_ff", b_data, 16'h00FF);
      if (m == 644 + 256) chk("b_col_wrap", {b_de, b_data}, 17'h10000);
      if (m == 924) b_sel = 2'd1;
      if (m == 925) chk("b_const_next", b_data, 16'hA5A5);
      if (m == 1263) b_sel = 2'd3;
      if (m == 2239) chk("b_busy_last", b_busy, 1);
      if (m == 2240) chk("b_busy_done", b_busy, 0);
      if (m == 2242)
        chk("b_idle_outputs", {b_vs, b_hs, b_de, b_fld, b_busy, b_data}, 0);
    end
    chk("b_queue_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
